ks_pipe_adder: RTL

Pipelined, handshaked 16-bit Kogge-Stone adder. It accepts one operand pair per cycle from an initiator such as a stimulus driver or an upstream datapath, and returns `{cout,sum}` after a fixed latency. The block is the responder side of the A/B/cin → sum/cout adder interface: it registers every prefix level so the adder can close timing inside the larger datapath, and it supports downstream backpressure.

---
 rtl/ks_pipe_adder_if.sv | 42 ++++
 rtl/ks_pipe_adder.sv | 112 +++++++++++
 2 files changed

// File: rtl/ks_pipe_adder_if.sv
// ---------------------------------------------------------------------------
// ks_pipe_adder_if
//
// Handshake bundle between an initiator and the pipelined Kogge-Stone adder.
// The initiator (master) presents operand pairs and drains results; the adder
// (slave) accepts operands and returns {cout,sum}.
//
// Signals:
//   in_valid   master->slave  operand pair present
//   in_ready   slave->master  adder can accept this cycle
//   A, B       master->slave  WIDTH-bit operands
//   cin        master->slave  per-transaction carry-in
//   out_valid  slave->master  result present
//   out_ready  master->slave  consumer accepts result
//   sum        slave->master  (A+B+cin) mod 2^WIDTH
//   cout       slave->master  bit WIDTH of A+B+cin
// ---------------------------------------------------------------------------
interface ks_pipe_adder_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/ks_pipe_adder.sv
// ---------------------------------------------------------------------------
// ks_pipe_adder
//
// Pipelined, handshaked WIDTH-bit Kogge-Stone adder. Every prefix level is
// registered so the adder closes timing inside a larger datapath. One operand
// pair can be accepted per cycle; the result appears log2(WIDTH)+1 cycles
// after acceptance unless the consumer applies backpressure.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset; clears all valid and data state
//   bus    ks_pipe_adder_if.slave: in_valid/in_ready/A/B/cin in,
//          out_valid/out_ready/sum/cout out
//
// WIDTH must be a power of two and at least 4.
// ---------------------------------------------------------------------------
module ks_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ks_pipe_adder_if.slave  bus
);

    // Stage 0 holds generate/propagate, stages 1..LAST each hold one prefix
    // level, so there are LAT register stages and the last one feeds outputs.
    localparam int LAT  = $clog2(WIDTH) + 1;
    localparam int LAST = LAT - 1;

    logic [LAST:0]    vld;
    logic [WIDTH-1:0] gq [LAT];
    logic [WIDTH-1:0] pq [LAT];
    logic [WIDTH-1:0] rq [LAT];
    logic             cq [LAT];

    logic [WIDTH-1:0] gn [LAT];
    logic [WIDTH-1:0] pn [LAT];
    logic [WIDTH-1:0] rn [LAT];
    logic             cn [LAT];

    logic             advance;
    logic [WIDTH-1:0] am;
    logic [WIDTH-1:0] bm;
    logic             cm;

    // The whole pipe moves together whenever the output slot is free or is
    // being drained; bubbles are kept in place rather than collapsed.
    assign advance = !vld[LAST] || bus.out_ready;

    // Bubbles load zero data so the pipe never fills with X from idle inputs.
    assign am = bus.A & {WIDTH{bus.in_valid}};
    assign bm = bus.B & {WIDTH{bus.in_valid}};
    assign cm = bus.cin & bus.in_valid;

    // Next-state for every stage. Carry-in is folded into bit 0's generate,
    // which makes each final G_i the carry out of bit i including cin.
    always_comb begin
        for (int s = 0; s < LAT; s++) begin
            gn[s] = '0;
            pn[s] = '0;
            rn[s] = '0;
            cn[s] = 1'b0;
        end

        gn[0]    = am & bm;
        gn[0][0] = (am[0] & bm[0]) | ((am[0] ^ bm[0]) & cm);
        pn[0]    = am ^ bm;
        rn[0]    = am ^ bm;
        cn[0]    = cm;

        for (int s = 1; s < LAT; s++) begin
            gn[s] = gq[s-1];
            pn[s] = pq[s-1];
            rn[s] = rq[s-1];
            cn[s] = cq[s-1];
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << (s - 1))) begin
                    gn[s][i] = gq[s-1][i] | (pq[s-1][i] & gq[s-1][i - (1 << (s - 1))]);
                    pn[s][i] = pq[s-1][i] & pq[s-1][i - (1 << (s - 1))];
                end
            end
        end
    end

    // Single register bank for all stages; holds completely during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int s = 0; s < LAT; s++) begin
                gq[s] <= '0;
                pq[s] <= '0;
                rq[s] <= '0;
                cq[s] <= 1'b0;
            end
        end else if (advance) begin
            vld <= {vld[LAST-1:0], bus.in_valid};
            for (int s = 0; s < LAT; s++) begin
                gq[s] <= gn[s];
                pq[s] <= pn[s];
                rq[s] <= rn[s];
                cq[s] <= cn[s];
            end
        end
    end

    // Carry into bit i is G_{i-1}, with cin entering bit 0.
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld[LAST];
    assign bus.sum       = rq[LAST] ^ {gq[LAST][WIDTH-2:0], cq[LAST]};
    assign bus.cout      = gq[LAST][WIDTH-1];

endmodule
